// File: rtl/ctrl_seq.sv
// Processor control sequencer: PRAM boot load, fetch/decode/execute, vectored maskable IRQs, HALT.
// Optional ALU_WAIT timeout with sticky err_o when CTRL_SEQ_ALU_TIMEOUT_EN is defined.
module ctrl_seq #(
  parameter int unsigned INSTR_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH_PC = 12,
  parameter int unsigned PRAM_DEPTH    = 4096,
  parameter int unsigned OPCODE_LGNT   = 8,
  parameter int unsigned ADDR_WIDTH_OP = 4,
  parameter int unsigned IRQ_NUM       = 4,
  parameter logic [ADDR_WIDTH_PC-1:0] IRQ_BASE = 12'hF00,
  parameter int unsigned ALU_TIMEOUT   = 16
) (
  input  logic                     clk_i,
  input  logic                     a_reset_h,
  input  logic                     init_valid_i,
  input  logic [INSTR_WIDTH-1:0]   init_data_i,
  input  logic [INSTR_WIDTH-1:0]   pram_data_i,
  output logic [ADDR_WIDTH_PC-1:0] pram_adr_o,
  output logic                     pram_we_o,
  output logic [INSTR_WIDTH-1:0]   pram_wdata_o,
  output logic                     init_mode_o,
  input  logic [IRQ_NUM-1:0]       irq_i,
  input  logic [IRQ_NUM-1:0]       irq_mask_i,
  output logic [IRQ_NUM-1:0]       irq_ack_o,
  input  logic                     alu_valid_i,
  output logic [OPCODE_LGNT-1:0]   alu_op_o,
  output logic [ADDR_WIDTH_OP-1:0] adr_a_o,
  output logic [ADDR_WIDTH_OP-1:0] adr_b_o,
  output logic                     regfile_we_o,
  output logic                     wb_start_o,
  output logic                     wb_we_o,
  input  logic                     wb_ack_i,
  output logic                     halted_o,
  output logic                     err_o
);

  localparam int unsigned IDXW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;
  localparam logic [ADDR_WIDTH_PC-1:0] LAST = ADDR_WIDTH_PC'(PRAM_DEPTH - 1);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_ALU_WAIT,
    S_WB_REQ, S_WB_WAIT, S_IRQ, S_HALT
  } state_t;

  state_t                   state;
  logic [ADDR_WIDTH_PC-1:0] cnt, pc, epc;
  logic [INSTR_WIDTH-1:0]   ir;
  logic                     ien;
  logic [IDXW-1:0]          irq_idx, irq_sel;
  logic [IRQ_NUM-1:0]       pend;
  logic                     irq_found;
  logic [3:0]               cls;
  logic                     alu_expired;

  assign cls = ir[INSTR_WIDTH-1 -: 4];

  // Lowest unmasked pending channel wins.
  always_comb begin
    pend      = irq_i & ~irq_mask_i;
    irq_sel   = '0;
    irq_found = 1'b0;
    for (int unsigned i = 0; i < IRQ_NUM; i++) begin
      if (pend[i] && !irq_found) begin
        irq_sel   = IDXW'(i);
        irq_found = 1'b1;
      end
    end
  end

`ifdef CTRL_SEQ_ALU_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ALU_TIMEOUT + 1);
  logic [TW-1:0] alu_cnt;
  logic          err_q;

  // A valid on the last counted cycle still wins over the timeout.
  assign alu_expired = (state == S_ALU_WAIT) && !alu_valid_i &&
                       (alu_cnt == TW'(ALU_TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge a_reset_h) begin
    if (a_reset_h) begin
      alu_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_ALU_WAIT) alu_cnt <= alu_cnt + 1'b1;
      else                     alu_cnt <= '0;
      if (alu_expired) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign alu_expired = 1'b0;
  assign err_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge a_reset_h) begin
    if (a_reset_h) begin
      state   <= S_INIT;
      cnt     <= '0;
      pc      <= '0;
      epc     <= '0;
      ir      <= '0;
      ien     <= 1'b1;
      irq_idx <= '0;
    end else begin
      unique case (state)
        S_INIT: if (init_valid_i) begin
          if (cnt == LAST) begin
            state <= S_FETCH;
            pc    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FETCH: if (ien && irq_found) begin
          irq_idx <= irq_sel;
          state   <= S_IRQ;
        end else begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          ir    <= pram_data_i;
          pc    <= pc + 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          unique case (cls)
            4'd1:       state <= S_ALU_WAIT;
            4'd2, 4'd3: state <= S_WB_REQ;
            4'd4: begin
              pc    <= ir[ADDR_WIDTH_PC-1:0];
              state <= S_FETCH;
            end
            4'd6: begin
              pc    <= epc;
              ien   <= 1'b1;
              state <= S_FETCH;
            end
            4'd7:    state <= S_HALT;
            default: state <= S_FETCH;
          endcase
        end
        S_ALU_WAIT: begin
          if (alu_valid_i)      state <= S_FETCH;
          else if (alu_expired) state <= S_HALT;
        end
        S_WB_REQ:  state <= S_WB_WAIT;
        S_WB_WAIT: if (wb_ack_i) state <= S_FETCH;
        S_IRQ: begin
          epc   <= pc;
          pc    <= IRQ_BASE + ADDR_WIDTH_PC'(irq_idx);
          ien   <= 1'b0;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_INIT;
      endcase
    end
  end

  // Outputs decode from registered state; the strobes follow their handshake inputs in-cycle.
  always_comb begin
    init_mode_o  = (state == S_INIT);
    pram_adr_o   = (state == S_INIT) ? cnt : pc;
    pram_we_o    = (state == S_INIT) && init_valid_i;
    pram_wdata_o = (state == S_INIT) ? init_data_i : '0;
    irq_ack_o    = (state == S_IRQ) ? (IRQ_NUM'(1) << irq_idx) : '0;
    alu_op_o     = ir[INSTR_WIDTH-1 -: OPCODE_LGNT];
    adr_a_o      = ir[2*ADDR_WIDTH_OP-1:ADDR_WIDTH_OP];
    adr_b_o      = ir[ADDR_WIDTH_OP-1:0];
    regfile_we_o = ((state == S_EXEC) && (cls == 4'd0)) ||
                   ((state == S_ALU_WAIT) && alu_valid_i) ||
                   ((state == S_WB_WAIT) && wb_ack_i && (cls == 4'd2));
    wb_start_o   = (state == S_WB_REQ);
    wb_we_o      = ((state == S_WB_REQ) || (state == S_WB_WAIT)) && (cls == 4'd3);
    halted_o     = (state == S_HALT);
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq (PRAM_DEPTH=8) with a 1-cycle-latency PRAM model.
module tb_ctrl_seq;

  logic        clk = 1'b0;
  logic        a_reset_h;
  logic        init_valid_i;
  logic [15:0] init_data_i;
  logic [15:0] pram_data_i;
  logic [11:0] pram_adr_o;
  logic        pram_we_o;
  logic [15:0] pram_wdata_o;
  logic        init_mode_o;
  logic [3:0]  irq_i, irq_mask_i, irq_ack_o;
  logic        alu_valid_i;
  logic [7:0]  alu_op_o;
  logic [3:0]  adr_a_o, adr_b_o;
  logic        regfile_we_o, wb_start_o, wb_we_o, wb_ack_i, halted_o, err_o;
  logic [53:0] outs;

  int tests = 0;
  int fails = 0;
  logic [15:0] img [4096];
  logic [15:0] bw [8];

  always #5 clk = ~clk;

  always @(posedge clk) pram_data_i <= img[pram_adr_o];

  assign outs = {pram_adr_o, pram_we_o, pram_wdata_o, irq_ack_o, alu_op_o, adr_a_o, adr_b_o,
                 regfile_we_o, wb_start_o, wb_we_o, halted_o, err_o};

  ctrl_seq #(.PRAM_DEPTH(8)) dut (
    .clk_i(clk), .a_reset_h(a_reset_h),
    .init_valid_i(init_valid_i), .init_data_i(init_data_i),
    .pram_data_i(pram_data_i), .pram_adr_o(pram_adr_o), .pram_we_o(pram_we_o),
    .pram_wdata_o(pram_wdata_o), .init_mode_o(init_mode_o),
    .irq_i(irq_i), .irq_mask_i(irq_mask_i), .irq_ack_o(irq_ack_o),
    .alu_valid_i(alu_valid_i), .alu_op_o(alu_op_o), .adr_a_o(adr_a_o), .adr_b_o(adr_b_o),
    .regfile_we_o(regfile_we_o), .wb_start_o(wb_start_o), .wb_we_o(wb_we_o),
    .wb_ack_i(wb_ack_i), .halted_o(halted_o), .err_o(err_o)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    init_valid_i = 1'b0; init_data_i = '0; irq_i = '0; irq_mask_i = '0;
    alu_valid_i = 1'b0; wb_ack_i = 1'b0;
  endtask

  task automatic set_prog(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    for (int i = 0; i < 8; i++) bw[i] = 16'h5000;
    bw[0] = w0; bw[1] = w1; bw[2] = w2;
  endtask

  // Resets, loads bw[0..7] with a gap between words, returns in the first FETCH cycle.
  task automatic boot(input bit chk);
    a_reset_h = 1'b1;
    clear_inputs();
    nxt();
    a_reset_h = 1'b0;
    nxt();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        init_valid_i = 1'b0;
        #1;
        if (chk) begin
          tests++;
          if (pram_we_o !== 1'b0) begin fails++; $display("FAIL boot_gap_we %0d: got %b want 0", i, pram_we_o); end
        end
        nxt();
      end
      init_valid_i = 1'b1;
      init_data_i  = bw[i];
      img[i]       = bw[i];
      #1;
      if (chk) begin
        tests++;
        if ({pram_we_o, init_mode_o, pram_adr_o, pram_wdata_o} !== {1'b1, 1'b1, 12'(i), bw[i]}) begin
          fails++;
          $display("FAIL boot_write %0d: got we=%b init=%b adr=%h data=%h want we=1 init=1 adr=%h data=%h",
                   i, pram_we_o, init_mode_o, pram_adr_o, pram_wdata_o, 12'(i), bw[i]);
        end
      end
      nxt();
    end
    init_valid_i = 1'b0;
    init_data_i  = '0;
  endtask

  task automatic test_reset();
    a_reset_h = 1'b1;
    clear_inputs();
    #1;
    tests++;
    if (init_mode_o !== 1'b1) begin fails++; $display("FAIL reset_init_mode: got %b want 1", init_mode_o); end
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
  endtask

  task automatic test_boot();
    for (int i = 0; i < 8; i++) bw[i] = 16'(i);
    boot(1'b1);
    #1;
    tests++;
    if ({init_mode_o, pram_we_o, pram_adr_o} !== {1'b0, 1'b0, 12'h000}) begin
      fails++;
      $display("FAIL boot_first_fetch: got init=%b we=%b adr=%h want init=0 we=0 adr=000", init_mode_o, pram_we_o, pram_adr_o);
    end
  endtask

  task automatic test_alu();
    set_prog(16'h0A21, 16'h1B43, 16'h7000);
    boot(1'b0);
    for (int w = 0; w < 15; w++) begin
      alu_valid_i = (w == 10);
      #1;
      if (w < 12) begin
        tests++;
        if (regfile_we_o !== (w == 2 || w == 10)) begin fails++; $display("FAIL alu_we w%0d: got %b want %b", w, regfile_we_o, (w == 2 || w == 10)); end
      end
      if (w == 2) begin
        tests++;
        if ({alu_op_o, adr_a_o, adr_b_o} !== {8'h0A, 4'd2, 4'd1}) begin fails++; $display("FAIL alu_fields0: got op=%h a=%h b=%h want 0a 2 1", alu_op_o, adr_a_o, adr_b_o); end
      end
      if (w == 10) begin
        tests++;
        if ({alu_op_o, adr_a_o, adr_b_o} !== {8'h1B, 4'd4, 4'd3}) begin fails++; $display("FAIL alu_fields1: got op=%h a=%h b=%h want 1b 4 3", alu_op_o, adr_a_o, adr_b_o); end
      end
      if (w == 11) begin
        tests++;
        if (pram_adr_o !== 12'h002) begin fails++; $display("FAIL alu_next_fetch: got %h want 002", pram_adr_o); end
      end
      if (w == 14) begin
        tests++;
        if (halted_o !== 1'b1) begin fails++; $display("FAIL alu_halt: got %b want 1", halted_o); end
      end
      nxt();
    end
  endtask

  task automatic test_wb();
    set_prog(16'h2050, 16'h3050, 16'h7000);
    boot(1'b0);
    for (int w = 0; w < 13; w++) begin
      wb_ack_i = (w == 3 || w == 6 || w == 11);
      #1;
      tests++;
      if (wb_start_o !== (w == 3 || w == 10)) begin fails++; $display("FAIL wb_start w%0d: got %b want %b", w, wb_start_o, (w == 3 || w == 10)); end
      tests++;
      if (regfile_we_o !== (w == 6)) begin fails++; $display("FAIL wb_regwe w%0d: got %b want %b", w, regfile_we_o, (w == 6)); end
      if (w >= 3 && w <= 6) begin
        tests++;
        if (wb_we_o !== 1'b0) begin fails++; $display("FAIL wb_we_load w%0d: got %b want 0", w, wb_we_o); end
      end
      if (w == 10 || w == 11) begin
        tests++;
        if (wb_we_o !== 1'b1) begin fails++; $display("FAIL wb_we_store w%0d: got %b want 1", w, wb_we_o); end
      end
      if (w == 6) begin
        tests++;
        if (adr_a_o !== 4'd5) begin fails++; $display("FAIL wb_adr_a: got %h want 5", adr_a_o); end
      end
      if (w == 12) begin
        tests++;
        if (pram_adr_o !== 12'h002) begin fails++; $display("FAIL wb_next_fetch: got %h want 002", pram_adr_o); end
      end
      nxt();
    end
  endtask

  task automatic test_irq();
    logic [3:0]  exp_ack;
    logic [11:0] exp_adr;
    set_prog(16'h4010, 16'h5000, 16'h5000);
    img[12'h010] = 16'h5000;
    img[12'hF02] = 16'h6000;
    boot(1'b0);
    irq_mask_i = 4'b0010;
    for (int w = 0; w < 11; w++) begin
      irq_i = (w >= 3) ? 4'b0110 : 4'b0000;
      #1;
      exp_ack = (w == 4 || w == 9) ? 4'b0100 : 4'b0000;
      tests++;
      if (irq_ack_o !== exp_ack) begin fails++; $display("FAIL irq_ack w%0d: got %b want %b", w, irq_ack_o, exp_ack); end
      if (w == 3 || w == 5 || w == 8 || w == 10) begin
        exp_adr = (w == 5 || w == 10) ? 12'hF02 : 12'h010;
        tests++;
        if (pram_adr_o !== exp_adr) begin fails++; $display("FAIL irq_fetch w%0d: got %h want %h", w, pram_adr_o, exp_adr); end
      end
      nxt();
    end
    irq_i = '0;
  endtask

  task automatic test_jmp_wrap();
    set_prog(16'h4FFF, 16'h5000, 16'h5000);
    img[12'hFFF] = 16'h5000;
    boot(1'b0);
    for (int w = 0; w < 7; w++) begin
      #1;
      if (w == 3) begin
        tests++;
        if (pram_adr_o !== 12'hFFF) begin fails++; $display("FAIL jmp_target: got %h want fff", pram_adr_o); end
      end
      if (w == 6) begin
        tests++;
        if (pram_adr_o !== 12'h000) begin fails++; $display("FAIL pc_wrap: got %h want 000", pram_adr_o); end
      end
      nxt();
    end
  endtask

  task automatic test_halt();
    set_prog(16'h7000, 16'h5000, 16'h5000);
    boot(1'b0);
    for (int w = 0; w < 10; w++) begin
      irq_i = (w >= 3) ? 4'b1111 : 4'b0000;
      #1;
      tests++;
      if (halted_o !== (w >= 3)) begin fails++; $display("FAIL halt_flag w%0d: got %b want %b", w, halted_o, (w >= 3)); end
      if (w >= 3) begin
        tests++;
        if ({irq_ack_o, pram_adr_o} !== {4'b0000, 12'h001}) begin fails++; $display("FAIL halt_irq_ignored w%0d: got ack=%b adr=%h want 0000 001", w, irq_ack_o, pram_adr_o); end
      end
      nxt();
    end
    irq_i = '0;
  endtask

  task automatic test_reset_mid();
    set_prog(16'h2050, 16'h5000, 16'h5000);
    boot(1'b0);
    for (int w = 0; w < 4; w++) begin
      #1;
      if (w == 3) begin
        tests++;
        if (wb_start_o !== 1'b1) begin fails++; $display("FAIL rst_mid_start: got %b want 1", wb_start_o); end
      end
      nxt();
    end
    a_reset_h = 1'b1;
    wb_ack_i  = 1'b1;
    #1;
    tests++;
    if (init_mode_o !== 1'b1) begin fails++; $display("FAIL rst_mid_init: got %b want 1", init_mode_o); end
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL rst_mid_outputs: got %h want 0", outs); end
    nxt();
    a_reset_h = 1'b0;
    wb_ack_i  = 1'b0;
    nxt();
    #1;
    tests++;
    if ({init_mode_o, regfile_we_o, wb_start_o} !== 3'b100) begin fails++; $display("FAIL rst_mid_after: got %b want 100", {init_mode_o, regfile_we_o, wb_start_o}); end
  endtask

  task automatic test_timeout();
    logic exp_stop;
`ifdef CTRL_SEQ_ALU_TIMEOUT_EN
    exp_stop = 1'b1;
`else
    exp_stop = 1'b0;
`endif
    set_prog(16'h1000, 16'h1000, 16'h7000);
    boot(1'b0);
    for (int w = 0; w <= 140; w++) begin
      alu_valid_i = (w == 18);
      #1;
      if (w == 18) begin
        tests++;
        if ({regfile_we_o, err_o, halted_o} !== 3'b100) begin fails++; $display("FAIL tmo_last_cycle_valid: got %b want 100", {regfile_we_o, err_o, halted_o}); end
      end
      if (w == 19) begin
        tests++;
        if (pram_adr_o !== 12'h001) begin fails++; $display("FAIL tmo_next_fetch: got %h want 001", pram_adr_o); end
      end
      if (w == 37) begin
        tests++;
        if ({err_o, halted_o} !== 2'b00) begin fails++; $display("FAIL tmo_before: got %b want 00", {err_o, halted_o}); end
      end
      if (w == 38 || w == 140) begin
        tests++;
        if ({err_o, halted_o, regfile_we_o} !== {exp_stop, exp_stop, 1'b0}) begin
          fails++;
          $display("FAIL tmo_state w%0d: got err=%b halt=%b we=%b want err=%b halt=%b we=0", w, err_o, halted_o, regfile_we_o, exp_stop, exp_stop);
        end
      end
      nxt();
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) img[i] = 16'h5000;
    clear_inputs();
    a_reset_h = 1'b1;
    test_reset();
    test_boot();
    test_alu();
    test_wb();
    test_irq();
    test_jmp_wrap();
    test_halt();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Parametrised successor of the processor control FSM.
- Sequences the boot image load into PRAM, then fetch/decode/execute of PRAM instructions.
- Generalises that FSM to configurable instruction/PC/operand widths, a configurable PRAM depth, and IRQ_NUM vectored, maskable, prioritised interrupts.
- Adds multi-cycle ALU wait with timeout, HALT, and a sticky error flag; sits between PRAM, register file, ALU and the Wishbone master.

Parameters:
INSTR_WIDTH, 16, instruction / data word width
ADDR_WIDTH_PC, 12, PC and PRAM address width
PRAM_DEPTH, 4096, words loaded in INIT (<= 2^ADDR_WIDTH_PC)
OPCODE_LGNT, 8, ALU opcode width
ADDR_WIDTH_OP, 4, register operand address width
IRQ_NUM, 4, interrupt channels
IRQ_BASE, 12'hF00, vector base; channel k vectors to IRQ_BASE+k
ALU_TIMEOUT, 16, max ALU_WAIT cycles (used with timeout feature)

Ports:
clk_i  in  1  clock
a_reset_h  in  1  reset, asynchronous, active-high
init_valid_i  in  1  boot word valid
init_data_i  in  INSTR_WIDTH  boot word
pram_data_i  in  INSTR_WIDTH  PRAM read data, 1-cycle latency
pram_adr_o  out  ADDR_WIDTH_PC  PRAM address
pram_we_o  out  1  PRAM write enable (INIT only)
pram_wdata_o  out  INSTR_WIDTH  PRAM write data
init_mode_o  out  1  high during INIT
irq_i  in  IRQ_NUM  interrupt requests, level
irq_mask_i  in  IRQ_NUM  1 = channel masked
irq_ack_o  out  IRQ_NUM  one-hot acknowledge pulse
alu_valid_i  in  1  multi-cycle ALU result valid
alu_op_o  out  OPCODE_LGNT  ALU operation
adr_a_o  out  ADDR_WIDTH_OP  reg A address (write target)
adr_b_o  out  ADDR_WIDTH_OP  reg B address
regfile_we_o  out  1  reg A write strobe
wb_start_o  out  1  Wishbone start pulse
wb_we_o  out  1  Wishbone direction, 1 = write
wb_ack_i  in  1  Wishbone transfer done
halted_o  out  1  in HALT
err_o  out  1  sticky error

Behaviour:
- Reset values: all outputs 0 except init_mode_o=1. Internal regs: state=INIT, load counter=0, pc=0, epc=0, ir=0, ien=1. Reset mid-operation aborts any transaction; no pulse completes.
- Decode fields from ir:
  - cls = ir[INSTR_WIDTH-1 -: 4]
  - alu_op_o = ir[INSTR_WIDTH-1 -: OPCODE_LGNT]
  - adr_a_o = ir[2*ADDR_WIDTH_OP-1:ADDR_WIDTH_OP]
  - adr_b_o = ir[ADDR_WIDTH_OP-1:0]
  - target = ir[ADDR_WIDTH_PC-1:0]
- INIT: pram_adr_o = counter, pram_wdata_o = init_data_i, pram_we_o = init_valid_i. Counter increments on each valid word. Valid at counter == PRAM_DEPTH-1 -> FETCH with pc=0, init_mode_o=0 next cycle.
- FETCH:
  - Pending IRQ (ien & |(irq_i & ~irq_mask_i)) -> IRQ; no fetch.
  - Otherwise pram_adr_o = pc -> DECODE.
- DECODE: ir <= pram_data_i; pc <= pc+1 (wraps mod 2^ADDR_WIDTH_PC) -> EXEC.
- EXEC, by cls:
  - 0 (single-cycle ALU): regfile_we_o=1 for 1 cycle -> FETCH. 3 cycles/instruction.
  - 1 (multi-cycle ALU): -> ALU_WAIT. On the cycle alu_valid_i=1: regfile_we_o=1 -> FETCH.
  - 2 (load): -> WB_REQ (wb_start_o=1, wb_we_o=0) -> WB_WAIT. On the cycle wb_ack_i=1: regfile_we_o=1 -> FETCH.
  - 3 (store): as load, but wb_we_o=1 held through WB_REQ and WB_WAIT; no regfile write.
  - 4 (JMP): pc <= target -> FETCH.
  - 6 (RETI): pc <= epc, ien <= 1 -> FETCH.
  - 7 (HALT): -> HALT.
  - Others: NOP -> FETCH.
- wb_ack_i arriving in WB_REQ is ignored; only WB_WAIT samples it.
- IRQ (1 cycle):
  - Lowest unmasked pending index k wins.
  - irq_ack_o[k]=1 for this cycle.
  - epc <= pc; pc <= IRQ_BASE+k; ien <= 0 -> FETCH.
  - No nesting. Requests arriving while ien=0 stay pending (level) until RETI.
- HALT: halted_o=1; exits only on reset; IRQs ignored.
- irq_ack_o, wb_start_o and regfile_we_o are never asserted simultaneously.

Optional Feature:
CTRL_SEQ_ALU_TIMEOUT_EN
- Defined: ALU_WAIT counts cycles. If alu_valid_i has not been seen after ALU_TIMEOUT cycles: err_o <= 1 (sticky until reset), no regfile write, -> HALT. alu_valid_i on the final counted cycle still completes normally.
- Undefined: ALU_WAIT waits indefinitely; err_o tied 0.

Test Plan:
- Boot, PRAM_DEPTH=8: 8 init_valid_i pulses with gaps, data 16'h0000..0007 -> pram_we_o exactly 8 times at addr 0..7; init_mode_o falls after the 8th; first FETCH pram_adr_o=0.
- ALU: ir=16'h0A21 then 16'h1B43 with alu_valid_i 5 cycles after ALU_WAIT entry -> regfile_we_o once each; adr_a_o=2/adr_b_o=1 then adr_a_o=4/adr_b_o=3; 3 and 8 cycles per instruction.
- Wishbone: load 16'h2050 with wb_ack_i after 3 cycles, then store 16'h3050 -> one wb_start_o pulse each; wb_we_o 0 then 1; regfile_we_o only for the load, adr_a_o=5.
- Interrupt: irq_i=4'b0110, irq_mask_i=4'b0010 at pc=12'h010 -> irq_ack_o=4'b0100, next fetch address 12'hF02; RETI there -> fetch 12'h010; irq_i held -> re-taken.
- JMP/wrap: 16'h4FFF -> fetch 12'hFFF, next fetch 12'h000; 16'h7000 -> halted_o=1, IRQs ignored; a_reset_h mid-WB_WAIT -> init_mode_o=1, all outputs reset.
- Timeout (macro on, ALU_TIMEOUT=16): alu_valid_i never asserted -> err_o=1 and halted_o=1 after 16 ALU_WAIT cycles; macro off -> still waiting after 100 cycles, err_o=0.
